piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the serial-in
//  shift-register link. Accepts a WIDTH-bit word via valid/ready, shifts it
//  out MSB first on sout, one bit per clk50m cycle, with a frame qualifier.
//  A receiver doing sr <= {sr[W-2:0], sin} while sframe=1 holds the original
//  word after WIDTH bits. An optional idle gap is inserted between words.
// PARAMETERS
//  WIDTH       4  word width in bits; legal range 2..32
//  GAP_CYCLES  1  idle cycles forced after each word; legal range 0..15
// PORTS
//  clk50m     in   1          50 MHz clock; all flops on posedge
//  rst        in   1          async, active-high reset; asserting it clears all state immediately
//  din        in   WIDTH      parallel word; sampled when din_valid & din_ready
//  din_valid  in   1          word available
//  din_ready  out  1          block can accept a word this cycle (combinational)
//  sout       out  1          serial data, MSB first; 0 when sframe=0
//  sframe     out  1          high exactly while sout carries a valid bit
//  bit_cnt    out  $clog2(WIDTH)  bits remaining after the current one; WIDTH-1 down to 0
//  tx_done    out  1          1-cycle pulse after the last bit of a word
// BEHAVIOUR
//  Reset: state=IDLE; shreg, sout, sframe, bit_cnt, tx_done, gap_cnt all 0.
//   din_ready=0 while rst=1.
//  States: IDLE, SHIFT, GAP.
//  din_ready = !rst & (IDLE | (SHIFT & bit_cnt==0 & GAP_CYCLES==0)).
//  Accept at edge N (valid&ready): shreg<=din, sout<=din[WIDTH-1], sframe<=1,
//   bit_cnt<=WIDTH-1, state<=SHIFT.
//  Edge N+k (1<=k<=WIDTH-1): shift left; sout<=din[WIDTH-1-k];
//   bit_cnt<=WIDTH-1-k. After edge N+WIDTH-1: sout=din[0], bit_cnt=0.
//  Edge N+WIDTH (SHIFT, bit_cnt==0): tx_done<=1 for exactly one cycle.
//   - New word accepted (GAP_CYCLES=0 only): reload as above. sframe stays 1
//     with no bubble, so back-to-back words form a continuous bit stream.
//   - else if GAP_CYCLES>0: sframe<=0, sout<=0, gap_cnt<=GAP_CYCLES-1,
//     state<=GAP.
//   - else: sframe<=0, sout<=0, state<=IDLE.
//  GAP: din_ready=0. Each edge, if gap_cnt==0 then state<=IDLE, else
//   gap_cnt decrements. Total time in GAP = GAP_CYCLES cycles.
//  Latency: first bit on sout 1 cycle after acceptance. Word period is
//   WIDTH+GAP_CYCLES cycles, or WIDTH cycles when GAP_CYCLES=0 and words
//   are back-to-back.
//  din and din_valid are ignored whenever din_ready=0. din is not stored
//   except at acceptance, so a din change mid-word has no effect.
//  din_valid is not required to stay high. A word is committed only at
//   the accepting edge.
//  Reset mid-word: outputs go to reset values asynchronously. The partial
//   word is dropped and no tx_done is produced. Accept resumes the first
//   cycle after rst deasserts.
//  tx_done never coincides with sframe=1 of the same word. It may coincide
//   with sframe=1 of the next word in back-to-back mode.
// TESTING
//  1 Reset: assert rst mid-idle -> sout=0, sframe=0, tx_done=0, bit_cnt=0,
//    din_ready=0; release -> din_ready=1 with state IDLE.
//  2 Single word (WIDTH=4, GAP=1): din=4'b1011 -> sout=1,0,1,1 on 4
//    consecutive cycles, bit_cnt=3,2,1,0, sframe=1 for exactly those
//    4 cycles. Next cycle tx_done=1 and din_ready=0. One cycle later
//    din_ready=1.
//  3 Back-to-back (GAP=0): din_valid held, 4'hA then 4'h5 -> 8 contiguous
//    sframe cycles carrying 1010_0101, tx_done pulses twice, no bubble.
//  4 Ignore while busy: change din and toggle din_valid during SHIFT ->
//    output bit sequence unchanged, no extra word sent.
//  5 Reset mid-word: rst after 2 of 4 bits of 4'hC -> sframe/sout drop to 0
//    at once, no tx_done. Next word 4'h3 after release goes out cleanly
//    as 0,0,1,1.
//  6 Loopback: feed sout/sframe into a 4-bit receiver shift register; send
//    random words with GAP=0..3 -> receiver sr equals each din after its
//    tx_done.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word via valid/ready and
// shifts it out MSB first with a frame qualifier and an optional idle gap.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk50m,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     sout,
  output logic                     sframe,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     tx_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             sframe_d;
  logic             tx_done_d;
  logic [CW-1:0]    bit_cnt_d;
  logic [3:0]       gap_cnt, gap_cnt_d;
  logic             accept;

  // sout is the MSB of the shift register; the register is cleared outside a frame
  assign sout = shreg[WIDTH-1];

  always_comb begin
    din_ready = !rst && ((state == IDLE) ||
                         (NO_GAP && (state == SHIFT) && (bit_cnt == '0)));
    accept    = din_valid && din_ready;
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    sframe_d  = sframe;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    tx_done_d = 1'b0;

    unique case (state)
      IDLE: ;
      SHIFT: begin
        if (bit_cnt != '0) begin
          shreg_d   = {shreg[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt - 1'b1;
        end else begin
          tx_done_d = 1'b1;
          shreg_d   = '0;
          sframe_d  = 1'b0;
          if (NO_GAP) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the end-of-word path so back-to-back words keep
    // sframe high while tx_done for the previous word still pulses.
    if (accept) begin
      shreg_d   = din;
      sframe_d  = 1'b1;
      bit_cnt_d = LAST_IDX;
      state_d   = SHIFT;
    end
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      sframe  <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      sframe  <= sframe_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      tx_done <= tx_done_d;
    end
  end

endmodule
